// File: rtl/conc_stim_seq.sv
// Stimulus sequencer: replays a programmed list of {obs, rep, data} entries
// into a DUT, holding each entry for rep+1 cycles, in one-shot or loop mode.
module conc_stim_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned REP_W  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [REP_W+DATA_W:0]     wr_data,
    input  logic [ADDR_W-1:0]         last_idx,
    input  logic                      loop_en,
    input  logic                      start,
    input  logic                      stop,
    output logic [DATA_W-1:0]         stim_data,
    output logic                      obs,
    output logic [ADDR_W-1:0]         pc,
    output logic                      step,
    output logic                      busy,
    output logic                      done,
    output logic                      wr_err
);

    localparam int unsigned ENTRY_W = 1 + REP_W + DATA_W;

    typedef enum logic {StIdle, StRun} state_t;

    state_t              state_q;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [REP_W-1:0]    rep_cnt_q;
    logic [ADDR_W-1:0]   last_q;
    logic                loop_q;

    // Single read port: the entry that would be loaded on the next advance.
    logic [ADDR_W-1:0]   next_idx;
    logic [ENTRY_W-1:0]  rd_entry;
    logic                rd_obs;
    logic [REP_W-1:0]    rd_rep;
    logic [DATA_W-1:0]   rd_data;

    // Pick the next entry to fetch: 0 on start or wrap, else pc+1
    always_comb begin
        next_idx = pc + ADDR_W'(1);
        if (state_q == StIdle || pc == last_q) begin
            next_idx = '0;
        end
        rd_entry = mem[next_idx];
        rd_obs   = rd_entry[ENTRY_W-1];
        rd_rep   = rd_entry[DATA_W +: REP_W];
        rd_data  = rd_entry[DATA_W-1:0];
    end

    // Program memory write; only accepted while idle, so the playing entry never changes
    always_ff @(posedge clock) begin
        if (wr_en && state_q == StIdle) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Playback FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            stim_data <= '0;
            obs       <= 1'b0;
            pc        <= '0;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_err    <= 1'b0;
            rep_cnt_q <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
        end else begin
            step   <= 1'b0;
            done   <= 1'b0;
            wr_err <= wr_en && (state_q == StRun);
            unique case (state_q)
                StIdle: begin
                    // start together with stop is a no-op
                    if (start && !stop) begin
                        state_q   <= StRun;
                        last_q    <= last_idx;
                        loop_q    <= loop_en;
                        pc        <= '0;
                        stim_data <= rd_data;
                        obs       <= rd_obs;
                        rep_cnt_q <= rd_rep;
                        step      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StRun: begin
                    if (stop) begin
                        // Abort: pc and stim_data hold their current values
                        state_q <= StIdle;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        obs     <= 1'b0;
                    end else if (rep_cnt_q != '0) begin
                        rep_cnt_q <= rep_cnt_q - REP_W'(1);
                    end else if (pc != last_q || loop_q) begin
                        // next_idx already wraps to 0 at last_q
                        pc        <= next_idx;
                        stim_data <= rd_data;
                        obs       <= rd_obs;
                        rep_cnt_q <= rd_rep;
                        step      <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        obs     <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
